mem_req_initiator: RTL and testbench
====================================

Name: mem_req_initiator

Overview:
- Requester-side controller for the data-cache access interface (MEM[1:0], Addr, Wdata, Rdata, BUSY).
- Accepts one load/store at a time from the pipeline over a valid/ready handshake.
- Drives a single-cycle MEM command to the cache, tracks the cache's BUSY sequence to completion, and returns read data or a write acknowledge to the pipeline.
- Sits between the MEM stage and data_cache.

Parameters:
- ADDR_W, 32, width of the request address and of Addr.
- DATA_W, 32, width of write/read data.
- TIMEOUT, 64, watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  controller can accept a request this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data, valid with resp_valid when the request was a load.
- resp_err  out  1  timeout flag, valid with resp_valid.
- MEM  out  2  cache command: [1] = write, [0] = read, 00 = none.
- Addr  out  ADDR_W  cache address.
- Wdata  out  DATA_W  cache write data.
- Rdata  in  DATA_W  cache read data.
- BUSY  in  1  cache status: high when the cache is idle or presenting completion; low while a transaction is in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state = IDLE; MEM = 00; Addr = 0; Wdata = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0; internal write flag = 0; watchdog = 0.
- States:
  - IDLE: req_ready = BUSY. On req_valid && BUSY, latch req_addr into Addr, req_wdata into Wdata, and req_we into an internal write flag; go to ISSUE.
  - ISSUE: MEM = {we, ~we} for exactly this one cycle; go to WAIT_LO.
  - WAIT_LO: MEM = 00. On BUSY = 0, go to WAIT_HI.
  - WAIT_HI: on BUSY = 1, register Rdata into resp_rdata (loads only; stores leave resp_rdata unchanged) and go to DONE.
  - DONE: resp_valid = 1 for this one cycle; go to IDLE.
- req_ready is 0 in every state except IDLE. Exactly one command pulse is issued per accepted request.
- Addr and Wdata hold their latched values from ISSUE through DONE.
- Latency, counted from the edge that accepts the request (cache needs 3 cycles to complete a load and 2 to complete a store):
  - ISSUE at cycle 1.
  - Load: BUSY low cycles 2-4, high cycle 5, resp_valid in cycle 6.
  - Store: BUSY low cycles 2-3, high cycle 4, resp_valid in cycle 5.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE if BUSY = 1; no other bubble is inserted.
- BUSY low in IDLE (cache still busy after a reset mid-transaction): req_ready = 0; no command is issued until BUSY returns high.
- Reset mid-operation: immediately returns to IDLE with MEM = 00; no resp_valid is produced for the aborted request.
- A req_valid seen outside IDLE is ignored; the pipeline must hold it until req_ready.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_LO and increments every cycle in WAIT_LO and WAIT_HI.
  - When the count reaches TIMEOUT, go to DONE with resp_err = 1 and resp_rdata = 0.
  - resp_err = 0 on normal completion.
- Undefined: no counter is built, resp_err is tied to 0, and the controller waits indefinitely.

Test Plan:
- Load: req addr 0x0, we = 0 with a 3-cycle cache model returning Rdata 0x00000001 -> MEM = 01 for one cycle at cycle 1; resp_valid at cycle 6 with resp_rdata = 0x00000001.
- Store: addr 0x10, wdata 0xDEADBEEF -> MEM = 10 for one cycle with Addr = 0x10 and Wdata = 0xDEADBEEF held; resp_valid at cycle 5; a following load of 0x10 returns 0xDEADBEEF.
- Back-to-back: store then load with req_valid held -> second request accepted in the cycle after the first resp_valid; exactly two MEM pulses observed.
- Reset mid-transaction: assert rst during WAIT_LO -> MEM = 00 and resp_valid = 0 immediately; with BUSY held low after reset, req_ready stays 0 and no MEM pulse occurs until BUSY = 1.
- MEM_TIMEOUT_EN with TIMEOUT = 8: BUSY held low after issue -> resp_valid with resp_err = 1 eight cycles after entering WAIT_LO; next request is accepted normally.
- Stall: req_valid held while the controller is in WAIT_HI -> req_ready = 0 and no second MEM pulse is issued.

Source files
------------

// File: rtl/mem_req_initiator.sv
// -----------------------------------------------------------------------------
// mem_req_initiator
//
// Requester-side controller between the MEM pipeline stage and data_cache.
// Takes one load/store at a time from the pipeline, issues a single-cycle MEM
// command to the cache, follows the cache's BUSY low/high completion sequence
// and returns load data (or a store acknowledge) as a one-cycle pulse.
//
// Optional feature: define MEM_TIMEOUT_EN to build a watchdog that ends a
// transaction with resp_err = 1 after TIMEOUT cycles in WAIT_LO/WAIT_HI.
// Without it, resp_err is tied to 0 and the controller waits indefinitely.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   req_valid    pipeline request present
//   req_we       1 = store, 0 = load
//   req_addr     request address
//   req_wdata    store data
//   req_ready    controller accepts a request this cycle
//   resp_valid   one-cycle completion pulse
//   resp_rdata   load data, qualified by resp_valid for loads
//   resp_err     watchdog timeout flag, qualified by resp_valid
//   MEM          cache command: [1] = write, [0] = read, 00 = none
//   Addr, Wdata  cache address / write data, held from ISSUE through DONE
//   Rdata        cache read data
//   BUSY         cache status: high = idle or completing, low = in progress
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the controller state and
// BUSY (never on req_valid). The pipeline must keep req_valid and the request
// fields stable until the transfer; a request presented outside IDLE is simply
// not taken. resp_valid is a single-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module mem_req_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [1:0]        MEM,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Wdata,
    input  logic [DATA_W-1:0] Rdata,
    input  logic              BUSY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state;
    logic   we_q;     // latched req_we for the transaction in flight

    // BUSY low while idle means the cache is still finishing something started
    // before a reset; hold off the pipeline until it reports idle.
    assign req_ready = (state == S_IDLE) && BUSY;

    // The watchdog compare is meaningless for TIMEOUT below 1.
    if (TIMEOUT < 1) begin : g_timeout_below_one
    end

`ifdef MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;

    // The count is 0 in the first WAIT_LO cycle, so reaching TIMEOUT-1 here
    // means TIMEOUT cycles have been spent waiting.
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            MEM        <= 2'b00;
            Addr       <= '0;
            Wdata      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            we_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            resp_err   <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            // Both pulses last one cycle unless a state below re-asserts them.
            resp_valid <= 1'b0;
            MEM        <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req_valid && BUSY) begin
                        Addr  <= req_addr;
                        Wdata <= req_wdata;
                        we_q  <= req_we;
                        // Registered so the command is visible exactly in ISSUE.
                        MEM   <= {req_we, ~req_we};
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MEM_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
`ifdef MEM_TIMEOUT_EN
                    if (wd_expired) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if (!BUSY) state <= S_WAIT_HI;
                    end
`else
                    if (!BUSY) state <= S_WAIT_HI;
`endif
                end
                S_WAIT_HI: begin
                    // A genuine completion wins over a same-cycle timeout.
                    if (BUSY) begin
                        if (!we_q) resp_rdata <= Rdata;
`ifdef MEM_TIMEOUT_EN
                        resp_err   <= 1'b0;
`endif
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wd_expired) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
`timescale 1ns/1ps
module tb_mem_req_initiator;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  // response entry: {issue-relative done cycle, err, rdata, addr, wdata}
  localparam int RW = 32 + 1 + DW + AW + DW;
  // command entry: {issue cycle, MEM, addr, wdata}
  localparam int CW = 32 + 2 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [1:0]    MEM;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Wdata;
  logic [DW-1:0] Rdata;
  logic          BUSY;

  mem_req_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MEM(MEM), .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata), .BUSY(BUSY)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- cache model (3-cycle load, 2-cycle store) ----------------
  logic [DW-1:0] cache_mem [logic [AW-1:0]];
  logic          hold_low = 1'b0;
  int            c_cnt = 0;
  bit            c_fresh = 0;
  logic          c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;

  initial begin
    BUSY  = 1'b1;
    Rdata = '0;
    forever begin
      @(posedge clk); #1;
      c_fresh = 0;
      Rdata = $urandom;
      if (rst) begin
        c_cnt = 0;
      end else if (c_cnt > 0) begin
        c_cnt--;
        if (c_cnt == 0 && !c_we)
          Rdata = cache_mem.exists(c_addr) ? cache_mem[c_addr] : '0;
      end else if (MEM != 2'b00) begin
        c_we   = MEM[1];
        c_addr = Addr;
        if (MEM[1]) cache_mem[Addr] = Wdata;
        c_cnt   = MEM[1] ? 3 : 4;
        c_fresh = 1;
      end
      BUSY = !(hold_low || (c_cnt > 0 && !c_fresh));
    end
  end

  // ---------------- reference model + scoreboard queues ----------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] last_rdata = '0;
  int            busy_until = -1;
  int            last_issue = 0;
  int            last_done  = 0;
  logic [RW-1:0] resp_q[$];
  logic [CW-1:0] cmd_q[$];

  // Drive one request and hold it until it is taken. Returns 3ns after the
  // accepting edge with req_valid still high.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit expect_timeout);
    int n;
    bit ok;
    int issue_cyc;
    int done;
    logic          err;
    logic [DW-1:0] rd;
    n = 0;
    ok = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      if (req_ready && !rst) ok = 1;
    end
    chk("accept_wait", ok, 1);
    if (ok) begin
      issue_cyc = cyc + 1;   // cycle that starts at the accepting edge
      cmd_q.push_back({32'(issue_cyc), we, ~we, a, d});
      if (expect_timeout) begin
        done = issue_cyc + 1 + TO;   // TO cycles after entering WAIT_LO
        err  = 1'b1;
        rd   = '0;
      end else begin
        done = issue_cyc + (we ? 4 : 5);
        err  = 1'b0;
        if (we) begin
          ref_mem[a] = d;
          rd = last_rdata;
        end else begin
          rd = ref_mem.exists(a) ? ref_mem[a] : '0;
        end
      end
      last_rdata = rd;
      resp_q.push_back({32'(done), err, rd, a, d});
      busy_until = done;
      last_issue = issue_cyc;
      last_done  = done;
      @(posedge clk); #3;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (resp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_resp_q", resp_q.size(), 0);
    @(posedge clk); #3;
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    logic [CW-1:0] ec;
    logic [RW-1:0] er;
    @(posedge clk); #2;
    if (!rst) begin
      chk("req_ready", req_ready, (cyc > busy_until) && BUSY);

      if (cmd_q.size() > 0 && int'(cmd_q[0][CW-1 -: 32]) < cyc) begin
        ec = cmd_q.pop_front();
        chk("mem_pulse_missing", 0, 1);
      end
      if (MEM != 2'b00) begin
        if (cmd_q.size() == 0) begin
          chk("mem_unexpected", MEM, 2'b00);
        end else begin
          ec = cmd_q.pop_front();
          chk("mem_cycle", cyc, int'(ec[CW-1 -: 32]));
          chk("mem_cmd", MEM, ec[AW+DW+1 -: 2]);
          chk("mem_addr", Addr, ec[AW+DW-1 -: AW]);
          chk("mem_wdata", Wdata, ec[DW-1:0]);
        end
      end

      if (resp_q.size() > 0 && int'(resp_q[0][RW-1 -: 32]) < cyc) begin
        er = resp_q.pop_front();
        chk("resp_missing", 0, 1);
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", resp_valid, 1'b0);
        end else begin
          er = resp_q.pop_front();
          chk("resp_cycle", cyc, int'(er[RW-1 -: 32]));
          chk("resp_err", resp_err, er[2*DW+AW]);
          chk("resp_rdata", resp_rdata, er[2*DW+AW-1 -: DW]);
          chk("resp_addr_held", Addr, er[DW+AW-1 -: AW]);
          chk("resp_wdata_held", Wdata, er[DW-1:0]);
        end
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "time limit");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int d1;
    int gap;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    cache_mem[32'h0] = 32'h0000_0001;
    ref_mem[32'h0]   = 32'h0000_0001;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_mem", MEM, 2'b00);
    chk("rst_addr", Addr, 0);
    chk("rst_wdata", Wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    @(posedge clk); #3;

    // directed load, store, load-after-store
    issue(1'b0, 32'h0, 32'h0, 0);
    drain();
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    drain();
    issue(1'b0, 32'h10, 32'h0, 0);
    drain();

    // back-to-back with req_valid held across the first transaction
    issue(1'b1, 32'h20, 32'h1234_5678, 0);
    d1 = last_done;
    issue(1'b0, 32'h20, 32'h0, 0);
    chk("b2b_issue_cycle", last_issue, d1 + 2);
    drain();

    // reset while in WAIT_LO, cache then stays busy
    issue(1'b0, 32'h10, 32'h0, 0);
    @(negedge clk);          // ISSUE cycle
    @(negedge clk);          // WAIT_LO cycle
    hold_low = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_mem", MEM, 2'b00);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_rdata", resp_rdata, 0);
    resp_q.delete();
    cmd_q.delete();
    busy_until = -1;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    repeat (6) @(negedge clk);
    chk("busy_low_req_ready", req_ready, 0);
    chk("busy_low_mem", MEM, 2'b00);
    hold_low = 1'b0;
    issue(1'b0, 32'h0, 32'h0, 0);
    drain();

`ifdef MEM_TIMEOUT_EN
    issue(1'b0, 32'h10, 32'h0, 1);
    hold_low = 1'b1;
    drain();
    hold_low = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 0);
    drain();
`endif

    // randomized traffic over a small address set so loads hit earlier stores
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7)) << 4;
      d  = $urandom;
      issue(we, a, d, 0);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        req_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #3;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
